// File: rtl/bus_control_sync.sv
// Synchronised 8259A bus decoder: strobe sync, trailing-edge write detect, ICW/OCW sequencing.
// Define BUS_CTRL_READ_SELECT_EN to add the registered read_register_select output.
module bus_control_sync #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  init_done,
`ifdef BUS_CTRL_READ_SELECT_EN
    output logic [1:0]            read_register_select,
`endif
    output logic                  read
);

    localparam int unsigned BW = DATA_WIDTH + 4;
    localparam logic [BW-1:0] BusIdle = {3'b111, 1'b0, {DATA_WIDTH{1'b0}}};

    localparam logic [6:0] StbNone = 7'b0000000;
    localparam logic [6:0] StbIcw1 = 7'b0000001;
    localparam logic [6:0] StbIcw2 = 7'b0000010;
    localparam logic [6:0] StbIcw3 = 7'b0000100;
    localparam logic [6:0] StbIcw4 = 7'b0001000;
    localparam logic [6:0] StbOcw1 = 7'b0010000;
    localparam logic [6:0] StbOcw2 = 7'b0100000;
    localparam logic [6:0] StbOcw3 = 7'b1000000;

    typedef enum logic [2:0] {
        StUninit, StWaitIcw2, StWaitIcw3, StWaitIcw4, StReady
    } state_e;

    logic [BW-1:0] bus_raw, bus_s;
    assign bus_raw = {chip_select_n, read_enable_n, write_enable_n, A0, data_bus_in};

    // All bus lines share one chain so data and A0 stay aligned with the strobes.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign bus_s = bus_raw;
    end else begin : g_sync
        logic [BW-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BusIdle;
            end else begin
                sync_q[0] <= bus_raw;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end
        assign bus_s = sync_q[SYNC_STAGES-1];
    end

    logic                  cs_n_s, rd_n_s, wr_n_s, a0_s;
    logic [DATA_WIDTH-1:0] data_s;
    assign cs_n_s = bus_s[DATA_WIDTH+3];
    assign rd_n_s = bus_s[DATA_WIDTH+2];
    assign wr_n_s = bus_s[DATA_WIDTH+1];
    assign a0_s   = bus_s[DATA_WIDTH];
    assign data_s = bus_s[DATA_WIDTH-1:0];

    state_e                state_q, state_d;
    logic [6:0]            strobe_q, strobe_d;
    logic                  sngl_q, sngl_d, ic4_q, ic4_d;
    logic                  wr_active, wr_active_q, wr_done;
    logic                  hold_a0_q, hold_a0_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d, data_q, data_d;
    logic                  read_q, read_d;

    assign wr_active = ~cs_n_s & ~wr_n_s;
    assign wr_done   = wr_active_q & ~wr_active;
    assign read_d    = ~cs_n_s & ~rd_n_s & wr_n_s;

    always_comb begin
        hold_a0_d   = hold_a0_q;
        hold_data_d = hold_data_q;
        data_d      = data_q;
        if (wr_active) begin
            hold_a0_d   = a0_s;
            hold_data_d = data_s;
        end
        if (wr_done) data_d = hold_data_q;
    end

    always_comb begin
        state_d  = state_q;
        strobe_d = StbNone;
        sngl_d   = sngl_q;
        ic4_d    = ic4_q;
        if (wr_done) begin
            if (!hold_a0_q && hold_data_q[4]) begin
                strobe_d = StbIcw1;
                sngl_d   = hold_data_q[1];
                ic4_d    = hold_data_q[0];
                state_d  = StWaitIcw2;
            end else if (hold_a0_q) begin
                case (state_q)
                    StWaitIcw2: begin
                        strobe_d = StbIcw2;
                        state_d  = !sngl_q ? StWaitIcw3 : (ic4_q ? StWaitIcw4 : StReady);
                    end
                    StWaitIcw3: begin
                        strobe_d = StbIcw3;
                        state_d  = ic4_q ? StWaitIcw4 : StReady;
                    end
                    StWaitIcw4: begin
                        strobe_d = StbIcw4;
                        state_d  = StReady;
                    end
                    StReady: strobe_d = StbOcw1;
                    default: ;
                endcase
            end else if (state_q == StReady) begin
                strobe_d = hold_data_q[3] ? StbOcw3 : StbOcw2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StUninit;
            strobe_q    <= StbNone;
            sngl_q      <= 1'b0;
            ic4_q       <= 1'b0;
            wr_active_q <= 1'b0;
            hold_a0_q   <= 1'b0;
            hold_data_q <= '0;
            data_q      <= '0;
            read_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            sngl_q      <= sngl_d;
            ic4_q       <= ic4_d;
            wr_active_q <= wr_active;
            hold_a0_q   <= hold_a0_d;
            hold_data_q <= hold_data_d;
            data_q      <= data_d;
            read_q      <= read_d;
        end
    end

`ifdef BUS_CTRL_READ_SELECT_EN
    logic       ris_q, ris_d;
    logic [1:0] rrs_q, rrs_d;

    always_comb begin
        ris_d = ris_q;
        if (strobe_d == StbIcw1) ris_d = 1'b0;
        else if (strobe_d == StbOcw3 && hold_data_q[1]) ris_d = hold_data_q[0];
        rrs_d = 2'b00;
        if (read_d) rrs_d = a0_s ? 2'b11 : (ris_q ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ris_q <= 1'b0;
            rrs_q <= 2'b00;
        end else begin
            ris_q <= ris_d;
            rrs_q <= rrs_d;
        end
    end

    assign read_register_select = rrs_q;
`endif

    assign internal_data_bus = data_q;
    assign write_icw1        = strobe_q[0];
    assign write_icw2        = strobe_q[1];
    assign write_icw3        = strobe_q[2];
    assign write_icw4        = strobe_q[3];
    assign write_ocw1        = strobe_q[4];
    assign write_ocw2        = strobe_q[5];
    assign write_ocw3        = strobe_q[6];
    assign init_done         = (state_q == StReady);
    assign read              = read_q;

endmodule

// File: tb/tb_bus_control_sync.sv
// Directed, table-driven bench for bus_control_sync (DATA_WIDTH=8, SYNC_STAGES=2).
module tb_bus_control_sync;

    localparam int unsigned DW  = 8;
    localparam int unsigned SS  = 2;
    localparam int          LAT = SS + 1;
    localparam int          WIN = 6;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_ICW1 = 7'b0000001;
    localparam logic [6:0] S_ICW2 = 7'b0000010;
    localparam logic [6:0] S_ICW3 = 7'b0000100;
    localparam logic [6:0] S_ICW4 = 7'b0001000;
    localparam logic [6:0] S_OCW1 = 7'b0010000;
    localparam logic [6:0] S_OCW2 = 7'b0100000;
    localparam logic [6:0] S_OCW3 = 7'b1000000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] bus;
    logic          icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, init_done, read;
`ifdef BUS_CTRL_READ_SELECT_EN
    logic [1:0]    rrs;
`endif

    always #5 clock = ~clock;

    bus_control_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .chip_select_n     (cs_n),
        .read_enable_n     (rd_n),
        .write_enable_n    (wr_n),
        .A0                (a0),
        .data_bus_in       (din),
        .internal_data_bus (bus),
        .write_icw1        (icw1),
        .write_icw2        (icw2),
        .write_icw3        (icw3),
        .write_icw4        (icw4),
        .write_ocw1        (ocw1),
        .write_ocw2        (ocw2),
        .write_ocw3        (ocw3),
        .init_done         (init_done),
`ifdef BUS_CTRL_READ_SELECT_EN
        .read_register_select (rrs),
`endif
        .read              (read)
    );

    logic [6:0] stb;
    assign stb = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [6:0] exp_stb;
        logic       exp_init;
    } vec_t;

    vec_t       vecs [18];
    vec_t       hv;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       exp_init_now = 1'b0;
    logic [6:0] tr_stb  [1:WIN];
    logic       tr_init [1:WIN];
    logic       tr_rd   [1:WIN];
    logic [7:0] tr_bus  [1:WIN];
    int         acc, seen, cnt;
    logic [7:0] first_bus;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic observe();
        for (int k = 1; k <= WIN; k++) begin
            tick();
            tr_stb[k]  = stb;
            tr_init[k] = init_done;
            tr_rd[k]   = read;
            tr_bus[k]  = bus;
        end
    endtask

    function automatic int stb_ones();
        int s = 0;
        for (int k = 1; k <= WIN; k++) s += $countones(tr_stb[k]);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_acc();
        tick();
        acc += $countones(stb);
        if (stb != 0 && seen == 0) begin
            seen = 1;
            first_bus = bus;
        end
    endtask

    // Full write (cs and wr together), then trace the window after the trailing edge.
    task automatic run_vec(input vec_t v, input string tag);
        cs_n = 1'b0; wr_n = 1'b0; a0 = v.a0; din = v.d;
        repeat (3) tick();
        wr_n = 1'b1; cs_n = 1'b1;
        observe();
        check({tag, " strobe"}, {25'd0, tr_stb[LAT]}, {25'd0, v.exp_stb});
        check({tag, " pulses"}, stb_ones(), $countones(v.exp_stb));
        check({tag, " init_before"}, {31'd0, tr_init[LAT-1]}, {31'd0, exp_init_now});
        check({tag, " init"}, {31'd0, tr_init[LAT]}, {31'd0, v.exp_init});
        if (v.exp_stb != S_NONE) check({tag, " data"}, {24'd0, tr_bus[LAT]}, {24'd0, v.d});
        exp_init_now = v.exp_init;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h55, S_NONE, 1'b0};
        vecs[1]  = '{1'b0, 8'h08, S_NONE, 1'b0};
        vecs[2]  = '{1'b0, 8'h13, S_ICW1, 1'b0};
        vecs[3]  = '{1'b1, 8'h20, S_ICW2, 1'b0};
        vecs[4]  = '{1'b1, 8'h01, S_ICW4, 1'b1};
        vecs[5]  = '{1'b0, 8'h10, S_ICW1, 1'b0};
        vecs[6]  = '{1'b1, 8'h08, S_ICW2, 1'b0};
        vecs[7]  = '{1'b1, 8'h04, S_ICW3, 1'b1};
        vecs[8]  = '{1'b1, 8'hFF, S_OCW1, 1'b1};
        vecs[9]  = '{1'b0, 8'h20, S_OCW2, 1'b1};
        vecs[10] = '{1'b0, 8'h0B, S_OCW3, 1'b1};
        vecs[11] = '{1'b0, 8'h11, S_ICW1, 1'b0};
        vecs[12] = '{1'b0, 8'h20, S_NONE, 1'b0};
        vecs[13] = '{1'b0, 8'h0B, S_NONE, 1'b0};
        vecs[14] = '{1'b1, 8'h20, S_ICW2, 1'b0};
        vecs[15] = '{1'b0, 8'h13, S_ICW1, 1'b0};
        vecs[16] = '{1'b1, 8'h30, S_ICW2, 1'b0};
        vecs[17] = '{1'b1, 8'h02, S_ICW4, 1'b1};

        #1 reset_n = 1'b0;
        #1;
        check("async_reset bus", {24'd0, bus}, 32'd0);
        check("async_reset strobes", {25'd0, stb}, 32'd0);
        check("async_reset init/read", {30'd0, init_done, read}, 32'd0);
        repeat (3) tick();
        check("reset_held outputs", {15'd0, bus, stb, init_done, read}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 18; i++) run_vec(vecs[i], $sformatf("v%0d", i));

`ifdef BUS_CTRL_READ_SELECT_EN
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0;
        repeat (LAT) tick();
        check("rrs irr", {30'd0, rrs}, 32'd1);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (LAT) tick();
        hv = '{1'b0, 8'h0B, S_OCW3, 1'b1};
        run_vec(hv, "rr_ocw3");
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0;
        repeat (LAT) tick();
        check("rrs isr", {30'd0, rrs}, 32'd2);
        a0 = 1'b1;
        repeat (LAT) tick();
        check("rrs imr", {30'd0, rrs}, 32'd3);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (LAT) tick();
        check("rrs idle", {30'd0, rrs}, 32'd0);
`endif

        // Read blocked by an active write, released when wr rises.
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'hAA;
        cnt = 0;
        repeat (4) begin
            tick();
            if (read) cnt++;
        end
        check("rd_during_wr", cnt, 0);
        wr_n = 1'b1;
        observe();
        check("rd_before_lat", {31'd0, tr_rd[LAT-1]}, 32'd0);
        check("rd_at_lat", {31'd0, tr_rd[LAT]}, 32'd1);
        check("rd_wr strobe", {25'd0, tr_stb[LAT]}, {25'd0, S_OCW1});
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (4) tick();
        check("rd_release", {31'd0, read}, 32'd0);

        // Chip select rising ends the write.
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h5A;
        repeat (3) tick();
        cs_n = 1'b1;
        observe();
        check("cs_rise strobe", {25'd0, tr_stb[LAT]}, {25'd0, S_OCW1});
        check("cs_rise pulses", stb_ones(), 1);
        check("cs_rise data", {24'd0, tr_bus[LAT]}, 32'h5A);
        wr_n = 1'b1;
        observe();
        check("cs_rise wr_release", stb_ones(), 0);

        // Back-to-back writes with one idle cycle between.
        acc = 0; seen = 0; first_bus = '0;
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h11;
        tick_acc(); tick_acc();
        wr_n = 1'b1;
        tick_acc();
        wr_n = 1'b0; din = 8'h22;
        tick_acc(); tick_acc();
        wr_n = 1'b1; cs_n = 1'b1;
        repeat (6) tick_acc();
        check("b2b count", acc, 2);
        check("b2b first", {24'd0, first_bus}, 32'h11);
        check("b2b last", {24'd0, bus}, 32'h22);

        // Reset while an ICW1 write is held active in WAIT_ICW3.
        hv = '{1'b0, 8'h10, S_ICW1, 1'b0};
        run_vec(hv, "pre_rst icw1");
        hv = '{1'b1, 8'h08, S_ICW2, 1'b0};
        run_vec(hv, "pre_rst icw2");
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; din = 8'h13;
        repeat (3) tick();
        check("pre_rst bus", {24'd0, bus}, 32'h08);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst bus", {24'd0, bus}, 32'd0);
        check("mid_rst outputs", {23'd0, stb, init_done, read}, 32'd0);
        cs_n = 1'b1; wr_n = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        observe();
        check("post_rst pulses", stb_ones(), 0);
        check("post_rst init", {31'd0, tr_init[WIN]}, 32'd0);
        exp_init_now = 1'b0;
        hv = '{1'b1, 8'h04, S_NONE, 1'b0};
        run_vec(hv, "post_rst uninit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
